// File: rtl/pipelined_csa_adder.sv
// pipelined_csa_adder
// Parametrised pipelined carry-select adder with a valid/ready stream interface.
// The operand is cut into NSEG = WIDTH/SEG segments. Stage 1 ripple-adds every
// segment twice (carry-in 0 and carry-in 1) and resolves segment 0 with C0.
// Each later stage resolves one more segment by muxing on the carry of the
// segment below it. {C_Out,S} = A + B + C0, latency NSEG, one beat per clock.
// A single global stall (out_valid && !out_ready) freezes every stage.
// Optional feature macro: CSA_OVF_EN (signed overflow flag V; V is 0 without it).
module pipelined_csa_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_Out,
  output logic             V
);

  localparam int NSEG = WIDTH / SEG;

  generate
    if ((SEG < 1) || (WIDTH < SEG) || ((WIDTH % SEG) != 0)) begin : g_bad_params
      $error("pipelined_csa_adder: WIDTH must be a non-zero multiple of SEG");
    end
  endgenerate

  // Stage registers. Stage s has segments 0..s resolved in r_sum; segments
  // above s still hold their carry-in-0 candidate in r_sum and carry-in-1
  // candidate in r_sum1. r_cy[s] is the resolved carry out of segment s.
  logic [NSEG-1:0]  r_vld;
  logic [NSEG-1:0]  r_cy;
  logic [WIDTH-1:0] r_sum  [NSEG];
  logic [WIDTH-1:0] r_sum1 [NSEG];
  logic [NSEG-1:0]  r_cy0  [NSEG];
  logic [NSEG-1:0]  r_cy1  [NSEG];

  // Values about to be loaded into each stage on an advancing edge.
  logic [NSEG-1:0]  w_ld_cy;
  logic [WIDTH-1:0] w_ld_sum  [NSEG];
  logic [WIDTH-1:0] w_ld_sum1 [NSEG];
  logic [NSEG-1:0]  w_ld_cy0  [NSEG];
  logic [NSEG-1:0]  w_ld_cy1  [NSEG];

  // Per-segment candidate sums straight from the operands.
  logic [WIDTH-1:0] w_seg_sum0;
  logic [WIDTH-1:0] w_seg_sum1;
  logic [NSEG-1:0]  w_seg_cy0;
  logic [NSEG-1:0]  w_seg_cy1;

  logic w_stall;

  // The whole pipeline freezes only when a finished beat is not being taken.
  assign w_stall   = out_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_vld[NSEG-1];
  assign S         = r_sum[NSEG-1];
  assign C_Out     = r_cy[NSEG-1];

  // Ripple-add every segment under both carry-in assumptions.
  always_comb begin
    w_seg_sum0 = '0;
    w_seg_sum1 = '0;
    w_seg_cy0  = '0;
    w_seg_cy1  = '0;
    for (int j = 0; j < NSEG; j++) begin
      {w_seg_cy0[j], w_seg_sum0[j*SEG +: SEG]} =
        {1'b0, A[j*SEG +: SEG]} + {1'b0, B[j*SEG +: SEG]};
      {w_seg_cy1[j], w_seg_sum1[j*SEG +: SEG]} =
        {1'b0, A[j*SEG +: SEG]} + {1'b0, B[j*SEG +: SEG]} + {{SEG{1'b0}}, 1'b1};
    end
  end

  // Build the next contents of every stage: stage 0 resolves segment 0 with
  // C0, stage s resolves segment s with the carry held by stage s-1.
  always_comb begin
    w_ld_cy = '0;
    for (int s = 0; s < NSEG; s++) begin
      w_ld_sum[s]  = '0;
      w_ld_sum1[s] = '0;
      w_ld_cy0[s]  = '0;
      w_ld_cy1[s]  = '0;
    end

    w_ld_sum[0]  = w_seg_sum0;
    w_ld_sum1[0] = w_seg_sum1;
    w_ld_cy0[0]  = w_seg_cy0;
    w_ld_cy1[0]  = w_seg_cy1;
    if (C0) begin
      w_ld_sum[0][SEG-1:0] = w_seg_sum1[SEG-1:0];
      w_ld_cy[0]           = w_seg_cy1[0];
    end else begin
      w_ld_cy[0]           = w_seg_cy0[0];
    end

    for (int s = 1; s < NSEG; s++) begin
      w_ld_sum[s]  = r_sum[s-1];
      w_ld_sum1[s] = r_sum1[s-1];
      w_ld_cy0[s]  = r_cy0[s-1];
      w_ld_cy1[s]  = r_cy1[s-1];
      if (r_cy[s-1]) begin
        w_ld_sum[s][s*SEG +: SEG] = r_sum1[s-1][s*SEG +: SEG];
        w_ld_cy[s]                = r_cy1[s-1][s];
      end else begin
        w_ld_cy[s]                = r_cy0[s-1][s];
      end
    end
  end

  // Stage registers: cleared by reset, all advance together unless stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int s = 0; s < NSEG; s++) begin
        r_sum[s]  <= '0;
        r_sum1[s] <= '0;
        r_cy0[s]  <= '0;
        r_cy1[s]  <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= in_valid;
      for (int s = 1; s < NSEG; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
      r_cy <= w_ld_cy;
      for (int s = 0; s < NSEG; s++) begin
        r_sum[s]  <= w_ld_sum[s];
        r_sum1[s] <= w_ld_sum1[s];
        r_cy0[s]  <= w_ld_cy0[s];
        r_cy1[s]  <= w_ld_cy1[s];
      end
    end
  end

`ifdef CSA_OVF_EN
  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_f(input logic a_sign, input logic b_sign, input logic s_sign);
    ovf_f = (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

  logic [NSEG-1:0] r_sa;
  logic [NSEG-1:0] r_sb;
  logic            r_v;
  logic [NSEG-1:0] w_ld_sa;
  logic [NSEG-1:0] w_ld_sb;

  // Operand sign bits travel alongside their beat.
  always_comb begin
    w_ld_sa    = '0;
    w_ld_sb    = '0;
    w_ld_sa[0] = A[WIDTH-1];
    w_ld_sb[0] = B[WIDTH-1];
    for (int s = 1; s < NSEG; s++) begin
      w_ld_sa[s] = r_sa[s-1];
      w_ld_sb[s] = r_sb[s-1];
    end
  end

  // Sign pipeline and registered overflow flag, frozen together with S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa <= '0;
      r_sb <= '0;
      r_v  <= 1'b0;
    end else if (!w_stall) begin
      r_sa <= w_ld_sa;
      r_sb <= w_ld_sb;
      r_v  <= ovf_f(w_ld_sa[NSEG-1], w_ld_sb[NSEG-1], w_ld_sum[NSEG-1][WIDTH-1]);
    end
  end

  assign V = r_v;
`else
  assign V = 1'b0;
`endif

endmodule
